// File: rtl/pulse_rate_detector_pkg.sv
// Shared types and default tick periods for the rate divider / rate detector pair.
// Both ends pull their nominal periods from here so they always agree.
package pulse_rate_detector_pkg;

  typedef enum logic {SLOW = 1'b0, FAST = 1'b1} mode_t;

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} det_state_t;

  typedef enum logic [1:0] {CLS_SLOW, CLS_FAST, CLS_INVALID} rate_class_t;

  localparam int unsigned DEF_FAST_PERIOD = 750000;
  localparam int unsigned DEF_SLOW_PERIOD = 1500000;

  function automatic mode_t class_to_mode(rate_class_t c);
    return (c == CLS_FAST) ? FAST : SLOW;
  endfunction

endpackage

// File: rtl/pulse_rate_detector_interval_counter.sv
// Edge-cleared interval counter; it sticks at SAT_VAL once reached so that
// a long silence never wraps into something that looks like a valid period.
module interval_counter
  import pulse_rate_detector_pkg::*;
#(
  parameter int unsigned CNT_W   = 23,
  parameter int unsigned SAT_VAL = 3000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             saturated
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(SAT_VAL);

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clear)               count_d = '0;
    else if (count_q != SAT) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count     = count_q;
  assign saturated = (count_q == SAT);

endmodule

// File: rtl/pulse_rate_detector.sv
// Recovers the producer's FAST/SLOW rate mode from the spacing of tick edges,
// with lock hysteresis, a mode-change strobe and a loss-of-tick timeout.
module pulse_rate_detector
  import pulse_rate_detector_pkg::*;
#(
  parameter int unsigned CNT_W          = 23,
  parameter int unsigned FAST_PERIOD    = DEF_FAST_PERIOD,
  parameter int unsigned SLOW_PERIOD    = DEF_SLOW_PERIOD,
  parameter int unsigned TOL            = 1024,
  parameter int unsigned LOCK_COUNT     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 3000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  output mode_t            mode,
  output logic             locked,
  output logic             mode_change,
  output logic [CNT_W-1:0] period,
  output logic             timeout
);

  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);

  // One extra bit so count+1 and the upper bounds never wrap.
  localparam logic [CNT_W:0] F_LO = (FAST_PERIOD > TOL) ? (CNT_W+1)'(FAST_PERIOD - TOL) : '0;
  localparam logic [CNT_W:0] F_HI = (CNT_W+1)'(FAST_PERIOD + TOL);
  localparam logic [CNT_W:0] S_LO = (SLOW_PERIOD > TOL) ? (CNT_W+1)'(SLOW_PERIOD - TOL) : '0;
  localparam logic [CNT_W:0] S_HI = (CNT_W+1)'(SLOW_PERIOD + TOL);
  localparam logic [MW-1:0]    LOCK_N  = MW'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic             tick_q, armed_q, tick_edge;
  logic [CNT_W-1:0] count;
  logic             cnt_sat;
  logic [CNT_W:0]   p;
  rate_class_t      cls;
  mode_t            cls_mode;

  det_state_t       state_d, state_q;
  mode_t            mode_d, mode_q, cand_d, cand_q;
  logic             locked_d, locked_q, mc_d, mc_q, to_d, to_q, first_d, first_q;
  logic [CNT_W-1:0] period_d, period_q;
  logic [MW-1:0]    match_d, match_q, match_inc;

  // armed_q masks the first cycle after reset so a tick already high is not an event.
  assign tick_edge = tick & ~tick_q & armed_q;

  interval_counter #(.CNT_W(CNT_W), .SAT_VAL(TIMEOUT_CYCLES)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clear     (tick_edge),
    .count     (count),
    .saturated (cnt_sat)
  );

  always_comb begin
    p = (CNT_W+1)'(count) + (CNT_W+1)'(1);
    // A saturated count no longer represents a real interval.
    if (cnt_sat)                    cls = CLS_INVALID;
    else if (p >= F_LO && p <= F_HI) cls = CLS_FAST;
    else if (p >= S_LO && p <= S_HI) cls = CLS_SLOW;
    else                             cls = CLS_INVALID;
    cls_mode  = class_to_mode(cls);
    match_inc = (match_q >= LOCK_N) ? match_q : match_q + MW'(1);
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cand_d   = cand_q;
    locked_d = locked_q;
    mc_d     = 1'b0;
    to_d     = 1'b0;
    first_d  = first_q;
    period_d = period_q;
    match_d  = match_q;
    case (state_q)
      IDLE: if (tick_edge) begin
        state_d = ACQUIRE;
        match_d = '0;
      end
      ACQUIRE: if (tick_edge) begin
        period_d = p[CNT_W-1:0];
        if (cls == CLS_INVALID)      match_d = '0;
        else if (cls_mode == cand_q) match_d = match_inc;
        else begin
          cand_d  = cls_mode;
          match_d = MW'(1);
        end
        if (match_d >= LOCK_N) begin
          state_d  = LOCKED;
          mode_d   = cand_d;
          locked_d = 1'b1;
          mc_d     = first_q || (cand_d != mode_q);
          first_d  = 1'b0;
        end
      end
      LOCKED: if (tick_edge) begin
        period_d = p[CNT_W-1:0];
        if (cls == CLS_INVALID) begin
          state_d  = ACQUIRE;
          locked_d = 1'b0;
          match_d  = '0;
        end else if (cls_mode != mode_q) begin
          state_d  = ACQUIRE;
          locked_d = 1'b0;
          cand_d   = cls_mode;
          match_d  = MW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A same-cycle edge takes priority, hence the !tick_edge qualifier.
    if (state_q != IDLE && !tick_edge && count == TO_LAST) begin
      state_d  = IDLE;
      locked_d = 1'b0;
      to_d     = 1'b1;
      match_d  = '0;
      first_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      mode_q   <= SLOW;
      cand_q   <= SLOW;
      locked_q <= 1'b0;
      mc_q     <= 1'b0;
      to_q     <= 1'b0;
      first_q  <= 1'b1;
      period_q <= '0;
      match_q  <= '0;
      tick_q   <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cand_q   <= cand_d;
      locked_q <= locked_d;
      mc_q     <= mc_d;
      to_q     <= to_d;
      first_q  <= first_d;
      period_q <= period_d;
      match_q  <= match_d;
      tick_q   <= tick;
      armed_q  <= 1'b1;
    end
  end

  assign mode        = mode_q;
  assign locked      = locked_q;
  assign mode_change = mc_q;
  assign period      = period_q;
  assign timeout     = to_q;

endmodule

// File: tb/tb_pulse_rate_detector.sv
// Directed + randomized bench for pulse_rate_detector against an interval-based
// reference model (edge cycle numbers, class streak queue).
module tb_pulse_rate_detector;
  import pulse_rate_detector_pkg::*;

  localparam int CNT_W = 8;
  localparam int FP    = 8;
  localparam int SP    = 16;
  localparam int TOL   = 1;
  localparam int LOCKN = 2;
  localparam int TO    = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick = 1'b0;
  mode_t mode;
  logic locked, mode_change, timeout;
  logic [CNT_W-1:0] period;

  pulse_rate_detector #(
    .CNT_W(CNT_W), .FAST_PERIOD(FP), .SLOW_PERIOD(SP), .TOL(TOL),
    .LOCK_COUNT(LOCKN), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .mode(mode), .locked(locked),
    .mode_change(mode_change), .period(period), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, last_edge = 0, stim_edge = 0;
  int ph;            // 0 idle, 1 acquiring, 2 locked
  int streak[$];     // classes of consecutive matching intervals
  int exp_mode, exp_period;
  bit exp_locked, exp_mc, exp_to, first_m, armed_m, prev_tick;
  int mc_seen = 0, to_seen = 0, to_gap = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int classify(input int iv);
    if (iv >= FP - TOL && iv <= FP + TOL) return 1;
    if (iv >= SP - TOL && iv <= SP + TOL) return 0;
    return 2;
  endfunction

  task automatic model_reset();
    ph = 0; streak.delete();
    exp_mode = 0; exp_period = 0; exp_locked = 0; exp_mc = 0; exp_to = 0;
    first_m = 1; armed_m = 0; prev_tick = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mode"}, mode, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_mc"}, mode_change, 0);
    chk({tag, "_period"}, period, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  task automatic step(input logic t);
    bit is_edge;
    int iv, c;
    tick = t;
    @(posedge clk);
    #1;
    cyc++;
    is_edge = armed_m && t && !prev_tick;
    prev_tick = t; armed_m = 1;
    exp_mc = 0; exp_to = 0;
    if (is_edge) begin
      iv = cyc - last_edge;
      last_edge = cyc;
      if (ph == 0) begin
        ph = 1; streak.delete();
      end else begin
        exp_period = iv;
        c = classify(iv);
        if (ph == 1) begin
          if (c == 2) streak.delete();
          else begin
            if (streak.size() > 0 && streak[0] != c) streak.delete();
            streak.push_back(c);
          end
          if (streak.size() >= LOCKN) begin
            ph = 2;
            exp_mc = first_m || (c != exp_mode);
            first_m = 0;
            exp_mode = c;
          end
        end else if (c == 2) begin
          ph = 1; streak.delete();
        end else if (c != exp_mode) begin
          ph = 1; streak.delete(); streak.push_back(c);
        end
      end
    end else if (ph != 0 && cyc - last_edge == TO) begin
      ph = 0; exp_to = 1; streak.delete(); first_m = 1;
    end
    exp_locked = (ph == 2);
    chk("locked", locked, exp_locked);
    chk("mode", mode, exp_mode);
    chk("mode_change", mode_change, exp_mc);
    chk("period", period, exp_period);
    chk("timeout", timeout, exp_to);
    if (mode_change === 1'b1) mc_seen++;
    if (timeout === 1'b1) begin
      to_seen++;
      to_gap = cyc - stim_edge;
    end
  endtask

  task automatic pulses(input int per, input int n, input int width);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < per; j++) begin
        step(j < width);
        if (j == 0) stim_edge = cyc;
      end
  endtask

  // Reset asserted mid-cycle: outputs must clear without waiting for a clock.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 check_reset_vals("rst_async");
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_reset_vals("rst_hold");
    rst = 1'b0;
  endtask

  initial begin
    int per, w;
    do_reset();

    // SLOW lock after the third 16-cycle edge
    mc_seen = 0;
    pulses(16, 4, 1);
    chk("t1_locked", locked, 1);
    chk("t1_mode", mode, SLOW);
    chk("t1_period", period, 16);
    chk("t1_mc_count", mc_seen, 1);

    // switch to FAST
    mc_seen = 0;
    pulses(8, 3, 1);
    chk("t2_locked", locked, 1);
    chk("t2_mode", mode, FAST);
    chk("t2_period", period, 8);
    chk("t2_mc_count", mc_seen, 1);

    // back to SLOW, tolerance edges, then an invalid interval
    pulses(16, 3, 1);
    mc_seen = 0;
    pulses(17, 1, 1); pulses(15, 1, 1); pulses(16, 1, 1); pulses(12, 1, 1);
    chk("t3_tol_locked", locked, 1);
    pulses(16, 1, 1);
    chk("t3_inv_locked", locked, 0);
    chk("t3_inv_mode", mode, SLOW);
    chk("t3_inv_period", period, 12);
    chk("t3_mc_count", mc_seen, 0);

    // relock, then lose ticks
    pulses(16, 3, 1);
    chk("t4_pre_locked", locked, 1);
    to_seen = 0;
    repeat (50) step(1'b0);
    chk("t4_to_count", to_seen, 1);
    chk("t4_to_gap", to_gap, TO);
    chk("t4_locked", locked, 0);
    chk("t4_mode", mode, SLOW);
    chk("t4_period", period, 16);
    mc_seen = 0;
    pulses(16, 4, 1);
    chk("t4_relock", locked, 1);
    chk("t4_mc_count", mc_seen, 1);

    // wide ticks count once
    repeat (45) step(1'b0);
    pulses(16, 4, 5);
    chk("t5_locked", locked, 1);
    chk("t5_period", period, 16);

    // randomized intervals, including the timeout boundary 39/40/41
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(7, 0))
        0: per = 7;
        1: per = 8;
        2: per = 9;
        3: per = 15;
        4: per = 16;
        5: per = 17;
        6: per = $urandom_range(41, 39);
        default: per = $urandom_range(30, 3);
      endcase
      w = $urandom_range(per - 1, 1);
      pulses(per, 1, w);
    end

    // reset in ACQUIRE with tick high
    repeat (45) step(1'b0);
    pulses(16, 1, 1);
    repeat (5) step(1'b0);
    repeat (2) step(1'b1);
    chk("t6_pre_locked", locked, 0);
    do_reset();
    mc_seen = 0;
    repeat (5) step(1'b1);
    repeat (10) step(1'b0);
    pulses(16, 2, 1);
    chk("t6_no_spurious", locked, 0);
    pulses(16, 1, 1);
    chk("t6_locked", locked, 1);
    chk("t6_mc_count", mc_seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
